// File: rtl/seg7_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_if
// Description : Bus bundle between the processor-side output register and the
//               multiplexed seven-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_if #(
  parameter int DIGITS = 8
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic                  lz_en;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     sel;
  logic                  frame_done;

  // Data source side: supplies display contents, observes pins and strobe
  modport master (
    output load, value, dp, lz_en,
    input  seg, sel, frame_done
  );

  // Display controller side
  modport slave (
    input  load, value, dp, lz_en,
    output seg, sel, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed seven-segment display controller with
//               frame-synchronous double buffering, anti-ghost blanking,
//               leading-zero suppression and a frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int SEG_ACT_LOW  = 1,
  parameter int SEL_ACT_LOW  = 1
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan_if.slave   bus
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  c_div_max = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  c_idx_max = IDX_W'(DIGITS - 1);
  // "All off" pin levels double as XOR masks that convert active-high to pins
  localparam logic [7:0]        c_seg_off = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] c_sel_off = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}}
                                                               : {DIGITS{1'b0}};

  // Scan counters
  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Pending (written by load) and shadow (displayed) buffers
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_lz_q, pend_lz_d;
  logic                pend_v_q, pend_v_d;
  logic [4*DIGITS-1:0] shd_val_q, shd_val_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic                shd_lz_q, shd_lz_d;

  // Registered pin outputs
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   sel_q, sel_d;

  logic                w_div_last;
  logic                w_frame_last;
  logic                w_active;
  logic [3:0]          w_nib;
  logic                w_dp_bit;
  logic                w_nz_acc;
  logic                w_keep_sel;
  logic                w_lead_blank;
  logic [7:0]          w_seg_ah;
  logic [DIGITS-1:0]   w_sel_ah;

  // Hex nibble to active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign w_div_last   = (div_cnt_q == c_div_max);
  assign w_frame_last = w_div_last && (idx_q == c_idx_max);

  // Anti-ghost window: sel stays inactive for the first BLANK_CYCLES of a slot
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_active = 1'b1;
    end else begin : g_blank
      localparam logic [CNT_W-1:0] c_blank = CNT_W'(BLANK_CYCLES);
      assign w_active = (div_cnt_q >= c_blank);
    end
  endgenerate

  // Slot/digit counters: div_cnt wraps every DIV cycles and advances idx
  always_comb begin
    div_cnt_d = w_div_last ? '0 : div_cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (w_div_last) begin
      idx_d = (idx_q == c_idx_max) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Double buffer: loads collect in pending and move to shadow at the frame
  // boundary; a load in the boundary cycle itself goes straight to shadow
  always_comb begin
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_lz_d  = pend_lz_q;
    pend_v_d   = pend_v_q;
    shd_val_d  = shd_val_q;
    shd_dp_d   = shd_dp_q;
    shd_lz_d   = shd_lz_q;
    if (bus.load) begin
      pend_val_d = bus.value;
      pend_dp_d  = bus.dp;
      pend_lz_d  = bus.lz_en;
    end
    if (w_frame_last) begin
      if (bus.load) begin
        shd_val_d = bus.value;
        shd_dp_d  = bus.dp;
        shd_lz_d  = bus.lz_en;
        pend_v_d  = 1'b0;
      end else if (pend_v_q) begin
        shd_val_d = pend_val_q;
        shd_dp_d  = pend_dp_q;
        shd_lz_d  = pend_lz_q;
        pend_v_d  = 1'b0;
      end
    end else if (bus.load) begin
      pend_v_d = 1'b1;
    end
  end

  // Digit select, leading-zero test and decode for the next registered pins.
  // Scanning from the MSD down, w_nz_acc is set once any nibble or dp at or
  // above the current position is non-zero; that digit must then be shown.
  always_comb begin
    w_nib      = 4'h0;
    w_dp_bit   = 1'b0;
    w_nz_acc   = 1'b0;
    w_keep_sel = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_nz_acc = w_nz_acc | (|shd_val_q[4*i +: 4]) | shd_dp_q[i];
      if (idx_q == IDX_W'(i)) begin
        w_nib      = shd_val_q[4*i +: 4];
        w_dp_bit   = shd_dp_q[i];
        w_keep_sel = w_nz_acc;
      end
    end
    w_lead_blank = shd_lz_q && (idx_q != '0) && !w_keep_sel;

    w_seg_ah = 8'h00;
    w_sel_ah = '0;
    if (w_active) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          w_sel_ah[i] = 1'b1;
        end
      end
      if (!w_lead_blank) begin
        w_seg_ah = {w_dp_bit, hex_to_seg(w_nib)};
      end
    end
    seg_d = w_seg_ah ^ c_seg_off;
    sel_d = w_sel_ah ^ c_sel_off;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_lz_q  <= 1'b0;
      pend_v_q   <= 1'b0;
      shd_val_q  <= '0;
      shd_dp_q   <= '0;
      shd_lz_q   <= 1'b0;
      seg_q      <= c_seg_off;
      sel_q      <= c_sel_off;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_lz_q  <= pend_lz_d;
      pend_v_q   <= pend_v_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      shd_lz_q   <= shd_lz_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.sel        = sel_q;
  assign bus.frame_done = w_frame_last;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl (4 digits, DIV=4,
//               one blank cycle) with an active-high and an active-low copy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        lz_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(4)) bus_hi ();
  seg7_scan_if #(.DIGITS(4)) bus_lo ();

  assign bus_hi.load  = load;
  assign bus_hi.value = value;
  assign bus_hi.dp    = dp;
  assign bus_hi.lz_en = lz_en;
  assign bus_lo.load  = load;
  assign bus_lo.value = value;
  assign bus_lo.dp    = dp;
  assign bus_lo.lz_en = lz_en;

  seg7_scan_ctrl #(
    .DIGITS(4), .DIV(4), .BLANK_CYCLES(1), .SEG_ACT_LOW(0), .SEL_ACT_LOW(0)
  ) u_dut_hi (
    .clk(clk), .rst(rst), .bus(bus_hi)
  );

  seg7_scan_ctrl #(
    .DIGITS(4), .DIV(4), .BLANK_CYCLES(1), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)
  ) u_dut_lo (
    .clk(clk), .rst(rst), .bus(bus_lo)
  );

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [31:0] exp;   // {digit3, digit2, digit1, digit0} active-high seg
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] d, input logic lz);
    value = v;
    dp    = d;
    lz_en = lz;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  // Returns at the negedge inside a frame_done cycle
  task automatic wait_frame_done();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus_hi.frame_done) found = 1;
    end
    if (!found) begin
      errors++;
      checks++;
      $display("FAIL frame_done_timeout: got none expected pulse within 40 cycles");
    end
  endtask

  // Starting in a frame_done cycle, record each digit's seg over the next frame
  task automatic capture(output logic [31:0] got);
    got = 32'hEEEE_EEEE;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        case (bus_hi.sel)
          4'b0001: got[7:0]   = bus_hi.seg;
          4'b0010: got[15:8]  = bus_hi.seg;
          4'b0100: got[23:16] = bus_hi.seg;
          4'b1000: got[31:24] = bus_hi.seg;
          default: ;
        endcase
      end
    end
  endtask

  // Hold reset 3 cycles, release, then follow two frames of scanning with
  // an all-zero shadow (every digit reads "0")
  task automatic reset_and_scan(input string tag);
    logic [3:0] exp_sel;
    logic [7:0] exp_seg;
    int s;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tag, "_rst_seg"}, {24'h0, bus_hi.seg}, 32'h00);
      chk({tag, "_rst_sel"}, {28'h0, bus_hi.sel}, 32'h0);
      chk({tag, "_rst_fd"},  {31'h0, bus_hi.frame_done}, 32'h0);
      chk({tag, "_rst_seg_lo"}, {24'h0, bus_lo.seg}, 32'hFF);
      chk({tag, "_rst_sel_lo"}, {28'h0, bus_lo.sel}, 32'hF);
    end
    rst = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      s       = k - 1;
      exp_sel = ((s % 4) >= 1) ? (4'b0001 << ((s / 4) % 4)) : 4'b0000;
      exp_seg = (exp_sel != 4'b0000) ? 8'h3F : 8'h00;
      chk({tag, "_scan_sel"}, {28'h0, bus_hi.sel}, {28'h0, exp_sel});
      chk({tag, "_scan_seg"}, {24'h0, bus_hi.seg}, {24'h0, exp_seg});
      chk({tag, "_scan_fd"},  {31'h0, bus_hi.frame_done}, {31'h0, (k % 16) == 15});
      chk({tag, "_scan_sel_lo"}, {28'h0, bus_lo.sel}, {28'h0, ~exp_sel});
      chk({tag, "_scan_seg_lo"}, {24'h0, bus_lo.seg}, {24'h0, ~exp_seg});
    end
  endtask

  initial begin
    logic [31:0] got;
    bit          found;

    vecs[0] = '{value: 16'h1A8F, dp: 4'b0000, lz: 1'b0, exp: 32'h06_77_7F_71};
    vecs[1] = '{value: 16'h0030, dp: 4'b0000, lz: 1'b1, exp: 32'h00_00_4F_3F};
    vecs[2] = '{value: 16'h0000, dp: 4'b0000, lz: 1'b1, exp: 32'h00_00_00_3F};
    vecs[3] = '{value: 16'h2B4D, dp: 4'b0101, lz: 1'b0, exp: 32'h5B_FC_66_DE};
    vecs[4] = '{value: 16'hC96E, dp: 4'b0000, lz: 1'b1, exp: 32'h39_6F_7D_79};
    vecs[5] = '{value: 16'h0705, dp: 4'b0000, lz: 1'b1, exp: 32'h00_07_3F_6D};
    vecs[6] = '{value: 16'h0000, dp: 4'b0000, lz: 1'b0, exp: 32'h3F_3F_3F_3F};

    @(negedge clk);
    reset_and_scan("t1");

    // Table-driven display contents
    for (int v = 0; v < 7; v++) begin
      load_word(vecs[v].value, vecs[v].dp, vecs[v].lz);
      wait_frame_done();
      capture(got);
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("vec%0d_digit%0d", v, d), {24'h0, got[8*d +: 8]},
            {24'h0, vecs[v].exp[8*d +: 8]});
      end
    end

    // Last load before a boundary wins
    wait_frame_done();
    repeat (3) @(negedge clk);
    load_word(16'h1111, 4'h0, 1'b0);
    @(negedge clk);
    load_word(16'h2222, 4'h0, 1'b0);
    wait_frame_done();
    capture(got);
    chk("last_wins", got, 32'h5B5B_5B5B);

    // Load in the boundary cycle bypasses pending and clears pend_v
    load_word(16'h1111, 4'h0, 1'b0);
    wait_frame_done();
    value = 16'h3333;
    load  = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    capture(got);
    chk("bypass_frame1", got, 32'h4F4F_4F4F);
    wait_frame_done();
    capture(got);
    chk("bypass_frame2", got, 32'h4F4F_4F4F);

    // Reset while digit 2 is being scanned, with a load still pending
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus_hi.sel == 4'b0100) found = 1;
    end
    chk("t5_reach_idx2", {31'h0, found}, 32'h1);
    load_word(16'h7777, 4'h0, 1'b0);
    reset_and_scan("t5");

    // Active-low pins: digit 0 = 8, no dp
    load_word(16'h0008, 4'h0, 1'b0);
    wait_frame_done();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus_lo.sel == 4'b1110) begin
        found = 1;
        chk("lo_seg_8", {24'h0, bus_lo.seg}, 32'h80);
        chk("hi_seg_8", {24'h0, bus_hi.seg}, 32'h7F);
        chk("hi_sel_8", {28'h0, bus_hi.sel}, 32'h1);
      end
    end
    chk("lo_sel_found", {31'h0, found}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
